// File: rtl/pfir_pkg.sv
// pfir_pkg: shared state encoding, field widths and config validity rule for pfir_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pfir_pkg;

  localparam int DEC_W   = 6;
  localparam int ADDR_W  = 10;
  localparam int LEN_W   = 11;
  localparam int PDATA_W = 16;
  localparam int SPAN_W  = LEN_W + 1;

  typedef enum logic [2:0] {
    HALT,
    CHK,
    CLR,
    LOADL,
    LOADH,
    FLUSH,
    RUN
  } state_t;

  // A configuration is unusable if the decimator would divide by zero, the
  // coefficient window is inverted, or the window overruns the loaded program.
  function automatic logic cfg_bad(
    input logic [DEC_W-1:0]  dec,
    input logic [ADDR_W-1:0] ncoef,
    input logic [ADDR_W-1:0] acoef,
    input logic [LEN_W-1:0]  len
  );
    logic [SPAN_W-1:0] span;
    span = {2'b00, ncoef} + SPAN_W'(2);
    return (dec == '0) || (ncoef < acoef) ||
           ((len != '0) && (span >= {1'b0, len}));
  endfunction

endpackage

// File: rtl/pfir_seq_ld.sv
// pfir_seq_ld: splits each accepted 32-bit instruction into low then high program half-words.
// Latency: low half on pwr one cycle after the handshake, high half the cycle after that.
// Backpressure: iw_ready is high only while the sequencer sits in LOADL; stalls just hold LOADL.
module pfir_seq_ld
  import pfir_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               arm,
  input  logic               in_loadh,
  input  logic [LEN_W-1:0]   len,
  input  logic [31:0]        iw_data,
  input  logic               iw_valid,
  output logic               iw_ready,
  output logic               hs,
  output logic               last,
  output logic               pwr,
  output logic [PDATA_W-1:0] pdata
);

  logic [PDATA_W-1:0] hi;
  logic [LEN_W-1:0]   cnt;

  assign hs   = iw_valid & iw_ready;
  // The word finishing in this LOADH is the final one of the program.
  assign last = ((cnt + LEN_W'(1)) == len);

  // Registered ready so the upstream sees a clean handshake window per LOADL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) iw_ready <= 1'b0;
    else     iw_ready <= arm;
  end

  // Low half goes out on the handshake edge, the held high half on the LOADH edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr   <= 1'b0;
      pdata <= '0;
      hi    <= '0;
    end else if (hs) begin
      pwr   <= 1'b1;
      pdata <= iw_data[15:0];
      hi    <= iw_data[31:16];
    end else if (in_loadh) begin
      pwr   <= 1'b1;
      pdata <= hi;
    end else begin
      pwr   <= 1'b0;
    end
  end

  // Completed-instruction counter, restarted at every reconfiguration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (in_loadh) cnt <= cnt + LEN_W'(1);
  end

endmodule

// File: rtl/pfir_seq.sv
// pfir_seq: reprograms the polyphase FIR (program RAM + dec/ncoef/acoef) under reset; PFIR_SEQ_CHECK_EN adds config checks.
// Latency: cfg_go to done is 3 + 2*len + FLUSH_CYC cycles, plus one per LOADL cycle without iw_valid.
// Backpressure: instructions paced by iw_ready; upstream samples refused (s_rfd=0, fir_iv=0) outside RUN.
module pfir_seq
  import pfir_pkg::*;
#(
  parameter int FLUSH_CYC = 8
) (
  input  logic               clk,
  input  logic               mrst,
  input  logic               cfg_go,
  input  logic [DEC_W-1:0]   cfg_dec,
  input  logic [ADDR_W-1:0]  cfg_ncoef,
  input  logic [ADDR_W-1:0]  cfg_acoef,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [31:0]        iw_data,
  input  logic               iw_valid,
  output logic               iw_ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               s_iv,
  output logic               s_rfd,
  input  logic               fir_rfd,
  output logic               fir_iv,
  output logic               fir_mrst,
  output logic [DEC_W-1:0]   fir_dec,
  output logic [ADDR_W-1:0]  fir_ncoef,
  output logic [ADDR_W-1:0]  fir_acoef,
  output logic               prst,
  output logic               pwr,
  output logic [PDATA_W-1:0] pdata
);

  localparam int FW = $clog2(FLUSH_CYC + 1);

  state_t             state, next_state;
  logic [DEC_W-1:0]   sh_dec;
  logic [ADDR_W-1:0]  sh_ncoef, sh_acoef;
  logic [LEN_W-1:0]   sh_len;
  logic [FW-1:0]      fcnt;
  logic               accept, chk_bad, flush_end, ld_hs, ld_last;
  logic               busy_d, mrst_d, prst_d, done_d;

  assign accept    = cfg_go & ((state == HALT) | (state == RUN));
  assign flush_end = (fcnt == FW'(FLUSH_CYC - 1));

`ifdef PFIR_SEQ_CHECK_EN
  assign chk_bad = cfg_bad(sh_dec, sh_ncoef, sh_acoef, sh_len);
`else
  assign chk_bad = 1'b0;
`endif

  // Samples only reach the FIR while its configuration is consistent.
  assign s_rfd  = (state == RUN) & fir_rfd;
  assign fir_iv = (state == RUN) & s_iv;

  // State register.
  always_ff @(posedge clk or posedge mrst) begin
    if (mrst) state <= HALT;
    else      state <= next_state;
  end

  // Next-state logic; cfg_go is only honoured when idle (HALT) or running (RUN).
  always_comb begin
    next_state = state;
    case (state)
      HALT, RUN: if (cfg_go) next_state = CHK;
      CHK:       next_state = chk_bad ? HALT : CLR;
      CLR:       next_state = (sh_len == '0) ? FLUSH : LOADL;
      LOADL:     if (ld_hs) next_state = LOADH;
      LOADH:     next_state = ld_last ? FLUSH : LOADL;
      FLUSH:     if (flush_end) next_state = RUN;
      default:   next_state = HALT;
    endcase
  end

  // Output decode; fir_mrst stays up through the done cycle and drops once RUN is settled.
  always_comb begin
    busy_d = (next_state != HALT) && (next_state != RUN);
    mrst_d = !((state == RUN) && (next_state == RUN));
    prst_d = (state == CLR);
    done_d = (state == FLUSH) && (next_state == RUN);
  end

  // Register the decoded control outputs.
  always_ff @(posedge clk or posedge mrst) begin
    if (mrst) begin
      busy     <= 1'b0;
      fir_mrst <= 1'b1;
      prst     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy     <= busy_d;
      fir_mrst <= mrst_d;
      prst     <= prst_d;
      done     <= done_d;
    end
  end

  // Shadow the request, then publish all three FIR fields together on FLUSH entry.
  always_ff @(posedge clk or posedge mrst) begin
    if (mrst) begin
      sh_dec    <= '0;
      sh_ncoef  <= '0;
      sh_acoef  <= '0;
      sh_len    <= '0;
      fir_dec   <= '0;
      fir_ncoef <= '0;
      fir_acoef <= '0;
    end else begin
      if (accept) begin
        sh_dec   <= cfg_dec;
        sh_ncoef <= cfg_ncoef;
        sh_acoef <= cfg_acoef;
        sh_len   <= cfg_len;
      end
      if ((state != FLUSH) && (next_state == FLUSH)) begin
        fir_dec   <= sh_dec;
        fir_ncoef <= sh_ncoef;
        fir_acoef <= sh_acoef;
      end
    end
  end

  // Flush timer covers the FIR's internal reset delay and MAC drain.
  always_ff @(posedge clk or posedge mrst) begin
    if (mrst)                fcnt <= '0;
    else if (state != FLUSH) fcnt <= '0;
    else                     fcnt <= fcnt + FW'(1);
  end

`ifdef PFIR_SEQ_CHECK_EN
  // Sticky error, cleared by the next accepted request.
  always_ff @(posedge clk or posedge mrst) begin
    if (mrst)                         err <= 1'b0;
    else if (accept)                  err <= 1'b0;
    else if ((state == CHK) && chk_bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  pfir_seq_ld u_ld (
    .clk      (clk),
    .rst      (mrst),
    .clr      (state == CLR),
    .arm      (next_state == LOADL),
    .in_loadh (state == LOADH),
    .len      (sh_len),
    .iw_data  (iw_data),
    .iw_valid (iw_valid),
    .iw_ready (iw_ready),
    .hs       (ld_hs),
    .last     (ld_last),
    .pwr      (pwr),
    .pdata    (pdata)
  );

endmodule

// File: tb/tb_pfir_seq.sv
// tb_pfir_seq: randomized scenario bench for pfir_seq against a cycle-timing reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_pfir_seq;
  localparam int F = 8;

  logic        clk = 1'b0, mrst = 1'b1, cfg_go = 1'b0;
  logic [5:0]  cfg_dec = '0;
  logic [9:0]  cfg_ncoef = '0, cfg_acoef = '0;
  logic [10:0] cfg_len = '0;
  logic [31:0] iw_data = '0;
  logic        iw_valid = 1'b0, s_iv = 1'b0, fir_rfd = 1'b1;
  logic        iw_ready, busy, done, err, s_rfd, fir_iv, fir_mrst, prst, pwr;
  logic [5:0]  fir_dec;
  logic [9:0]  fir_ncoef, fir_acoef;
  logic [15:0] pdata;

  pfir_seq #(.FLUSH_CYC(F)) dut (
    .clk(clk), .mrst(mrst), .cfg_go(cfg_go), .cfg_dec(cfg_dec), .cfg_ncoef(cfg_ncoef),
    .cfg_acoef(cfg_acoef), .cfg_len(cfg_len), .iw_data(iw_data), .iw_valid(iw_valid),
    .iw_ready(iw_ready), .busy(busy), .done(done), .err(err), .s_iv(s_iv), .s_rfd(s_rfd),
    .fir_rfd(fir_rfd), .fir_iv(fir_iv), .fir_mrst(fir_mrst), .fir_dec(fir_dec),
    .fir_ncoef(fir_ncoef), .fir_acoef(fir_acoef), .prst(prst), .pwr(pwr), .pdata(pdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] pw_q[$];
  int pw_cyc[$], prst_cyc[$], done_cyc[$], iv_cyc[$];
  int mrst_hi = 0;
  logic [31:0] words[$];
  int gaps[$];
  int last_t, last_done, last_s;

  // Observe on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (pwr) begin pw_q.push_back(pdata); pw_cyc.push_back(cyc); end
    if (prst) prst_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (fir_iv || s_rfd) iv_cyc.push_back(cyc);
    if (fir_mrst) mrst_hi++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Issue a request for the current words/gaps and check timing, data and final fields.
  task automatic run_load(input string nm, input logic [5:0] dec, input logic [9:0] nc,
                          input logic [9:0] ac);
    int n, t, h, s, k, exp_done, got;
    logic [15:0] ehw[$];
    int ecy[$];
    n = words.size();
    pw_q.delete(); pw_cyc.delete(); prst_cyc.delete(); done_cyc.delete();
    @(posedge clk); #1;
    cfg_dec = dec; cfg_ncoef = nc; cfg_acoef = ac; cfg_len = 11'(n); cfg_go = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    cfg_go = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || fir_mrst !== 1'b1 || s_rfd !== 1'b0) begin
      n_bad++;
      $display("FAIL %s go+1 busy/fir_mrst/s_rfd: got %b/%b/%b want 1/1/0", nm, busy, fir_mrst, s_rfd);
    end
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (iw_ready !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
      if (k >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL %s iw_ready word %0d: got timeout want ready", nm, i);
        break;
      end
      repeat (gaps[i]) begin @(posedge clk); #1; end
      iw_data = words[i]; iw_valid = 1'b1;
      @(posedge clk); #1;
      iw_valid = 1'b0;
    end
    k = 0;
    while (done_cyc.size() == 0 && k < 300) begin @(posedge clk); #1; k++; end
    // Reference: low/high pair per word, handshake every 2 cycles plus requested stalls.
    s = 0;
    h = t + 3;
    for (int i = 0; i < n; i++) begin
      s += gaps[i];
      h += gaps[i];
      ehw.push_back(words[i][15:0]);  ecy.push_back(h + 1);
      ehw.push_back(words[i][31:16]); ecy.push_back(h + 2);
      h += 2;
    end
    exp_done = t + 3 + 2 * n + F + s;
    got = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_cmp++;
    if (done_cyc.size() != 1 || got != exp_done) begin
      n_bad++;
      $display("FAIL %s done: got cycle %0d (count %0d) want cycle %0d (count 1)", nm, got,
               done_cyc.size(), exp_done);
    end
    n_cmp++;
    if (pw_q.size() != 2 * n) begin
      n_bad++;
      $display("FAIL %s pwr count: got %0d want %0d", nm, pw_q.size(), 2 * n);
    end
    for (int i = 0; i < 2 * n && i < pw_q.size(); i++) begin
      n_cmp++;
      if (pw_q[i] !== ehw[i] || pw_cyc[i] != ecy[i]) begin
        n_bad++;
        $display("FAIL %s halfword %0d: got %h @%0d want %h @%0d", nm, i, pw_q[i], pw_cyc[i],
                 ehw[i], ecy[i]);
      end
    end
    got = (prst_cyc.size() > 0) ? prst_cyc[0] : -1;
    n_cmp++;
    if (prst_cyc.size() != 1 || got != t + 3) begin
      n_bad++;
      $display("FAIL %s prst: got cycle %0d (count %0d) want cycle %0d (count 1)", nm, got,
               prst_cyc.size(), t + 3);
    end
    n_cmp++;
    if (fir_dec !== dec || fir_ncoef !== nc || fir_acoef !== ac) begin
      n_bad++;
      $display("FAIL %s fields dec/ncoef/acoef: got %0d/%0d/%0d want %0d/%0d/%0d", nm, fir_dec,
               fir_ncoef, fir_acoef, dec, nc, ac);
    end
    n_cmp++;
    if (fir_mrst !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after done fir_mrst/busy/err: got %b/%b/%b want 0/0/0", nm, fir_mrst,
               busy, err);
    end
    last_t = t; last_done = exp_done; last_s = s;
  endtask

  task automatic test_reset;
    mrst = 1'b1; s_iv = 1'b1; fir_rfd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (fir_mrst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        iw_ready !== 1'b0 || prst !== 1'b0 || pwr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset ctl fir_mrst/busy/done/err/iw_ready/prst/pwr: got %b%b%b%b%b%b%b want 1000000",
               fir_mrst, busy, done, err, iw_ready, prst, pwr);
    end
    n_cmp++;
    if (pdata !== '0 || fir_dec !== '0 || fir_ncoef !== '0 || fir_acoef !== '0 ||
        s_rfd !== 1'b0 || fir_iv !== 1'b0) begin
      n_bad++;
      $display("FAIL reset data pdata/dec/ncoef/acoef/s_rfd/fir_iv: got %h/%0d/%0d/%0d/%b/%b want 0",
               pdata, fir_dec, fir_ncoef, fir_acoef, s_rfd, fir_iv);
    end
    mrst = 1'b0; s_iv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (fir_mrst !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL halt idle fir_mrst/busy: got %b/%b want 1/0", fir_mrst, busy);
    end
  endtask

  task automatic test_len0;
    words.delete(); gaps.delete();
    run_load("len0", 6'd8, 10'd30, 10'd0);
  endtask

  task automatic test_back_to_back;
    words = '{32'hA0001234, 32'h40005678, 32'h8000FFFF};
    gaps  = '{0, 0, 0};
    run_load("b2b", 6'd4, 10'd0, 10'd0);
  endtask

  task automatic test_stall;
    words = '{32'hA0001234, 32'h40005678, 32'h8000FFFF};
    gaps  = '{0, 5, 0};
    run_load("stall", 6'd12, 10'd0, 10'd0);
  endtask

  task automatic test_gating;
    int n_in;
    logic seen;
    s_iv = 1'b1; fir_rfd = 1'b1;
    #1;
    n_cmp++;
    if (fir_iv !== 1'b1 || s_rfd !== 1'b1) begin
      n_bad++;
      $display("FAIL gate run fir_iv/s_rfd: got %b/%b want 1/1", fir_iv, s_rfd);
    end
    words.delete(); gaps.delete();
    for (int i = 0; i < 3; i++) begin words.push_back($urandom); gaps.push_back(0); end
    iv_cyc.delete(); mrst_hi = 0;
    run_load("gate", 6'(($urandom_range(1, 63))), 10'd0, 10'd0);
    @(posedge clk); #1;
    n_in = 0; seen = 1'b0;
    foreach (iv_cyc[i]) begin
      if (iv_cyc[i] > last_t && iv_cyc[i] < last_done) n_in++;
      if (iv_cyc[i] == last_done + 1) seen = 1'b1;
    end
    n_cmp++;
    if (n_in != 0) begin
      n_bad++;
      $display("FAIL gate reconfig window: got %0d open cycles want 0", n_in);
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++;
      $display("FAIL gate reopen: got closed at done+1 want open");
    end
    n_cmp++;
    if (mrst_hi != 3 + 2 * 3 + F + last_s) begin
      n_bad++;
      $display("FAIL gate fir_mrst cycles: got %0d want %0d", mrst_hi, 3 + 2 * 3 + F + last_s);
    end
    s_iv = 1'b0;
  endtask

  task automatic test_mrst_abort;
    int k;
    @(posedge clk); #1;
    cfg_dec = 6'd5; cfg_ncoef = 10'd1; cfg_acoef = 10'd0; cfg_len = 11'd4; cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0; iw_data = $urandom; iw_valid = 1'b1;
    k = 0;
    while (pwr !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL abort reach LOADH: got timeout want pwr");
    end
    mrst = 1'b1; iw_valid = 1'b0;
    #1;
    n_cmp++;
    if (fir_mrst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || iw_ready !== 1'b0 ||
        prst !== 1'b0 || pwr !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort ctl fir_mrst/busy/done/iw_ready/prst/pwr/err: got %b%b%b%b%b%b%b want 1000000",
               fir_mrst, busy, done, iw_ready, prst, pwr, err);
    end
    n_cmp++;
    if (pdata !== '0 || fir_dec !== '0 || fir_ncoef !== '0 || fir_acoef !== '0 || s_rfd !== 1'b0) begin
      n_bad++;
      $display("FAIL abort data pdata/dec/ncoef/acoef/s_rfd: got %h/%0d/%0d/%0d/%b want 0",
               pdata, fir_dec, fir_ncoef, fir_acoef, s_rfd);
    end
    @(posedge clk); #1;
    mrst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (fir_mrst !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort stays halted fir_mrst/busy: got %b/%b want 1/0", fir_mrst, busy);
    end
    words.delete(); gaps.delete();
`ifdef PFIR_SEQ_CHECK_EN
    for (int i = 0; i < 3; i++) begin words.push_back($urandom); gaps.push_back(0); end
`else
    words.push_back($urandom); gaps.push_back(0);
`endif
    run_load("reload", 6'd7, 10'd0, 10'd0);
  endtask

  task automatic test_check;
`ifdef PFIR_SEQ_CHECK_EN
    prst_cyc.delete(); done_cyc.delete();
    @(posedge clk); #1;
    cfg_dec = 6'd0; cfg_ncoef = 10'd0; cfg_acoef = 10'd0; cfg_len = 11'd4; cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || fir_mrst !== 1'b1) begin
      n_bad++;
      $display("FAIL check err/busy/fir_mrst: got %b/%b/%b want 1/0/1", err, busy, fir_mrst);
    end
    n_cmp++;
    if (prst_cyc.size() != 0 || done_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL check prst/done pulses: got %0d/%0d want 0/0", prst_cyc.size(), done_cyc.size());
    end
    words.delete(); gaps.delete();
    for (int i = 0; i < 3; i++) begin words.push_back($urandom); gaps.push_back(0); end
    run_load("check_ok", 6'd9, 10'd0, 10'd0);
`else
    words.delete(); gaps.delete();
    for (int i = 0; i < 2; i++) begin words.push_back($urandom); gaps.push_back(1); end
    run_load("nocheck", 6'd0, 10'd5, 10'd9);
`endif
  endtask

  task automatic test_random;
    int n;
    logic [9:0] nc, ac;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(3, 8);
      nc = 10'($urandom_range(0, n - 3));
      ac = 10'($urandom_range(0, int'(nc)));
      words.delete(); gaps.delete();
      for (int i = 0; i < n; i++) begin
        words.push_back($urandom);
        gaps.push_back($urandom_range(0, 3));
      end
      run_load("random", 6'($urandom_range(1, 63)), nc, ac);
    end
  endtask

  initial begin
    test_reset();
    test_len0();
    test_back_to_back();
    test_stall();
    test_gating();
    test_mrst_abort();
    test_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pfir_seq.md
# pfir_seq

Configuration sequencer for the 1024-tap dual-rail polyphase FIR engine.
- Accepts a reconfiguration command and a stream of 32-bit filter instructions.
- Writes the instructions into the FIR program RAM as 16-bit half-words over the prst/pwr/pdata port.
- Holds the FIR in reset while its state is inconsistent, then applies the new dec/ncoef/acoef together.
- Gates the sample input so no sample is written into the FIR buffer during reconfiguration.

## Interface
Parameters:
- FLUSH_CYC, 8: cycles fir_mrst is held after the last program write; must be ≥ 6 to cover the FIR's internal 4-cycle reset delay plus MAC drain.

Ports:
- clk  in  1  master clock; also drives the FIR programming clock.
- mrst  in  1  master reset, asynchronous, active-high.
- cfg_go  in  1  single-cycle reconfiguration request.
- cfg_dec  in  6  new decimation modulus, sampled on cfg_go.
- cfg_ncoef  in  10  new ending coefficient address minus two, sampled on cfg_go.
- cfg_acoef  in  10  new starting coefficient address, sampled on cfg_go.
- cfg_len  in  11  number of 32-bit instructions to load, 0..1024, sampled on cfg_go.
- iw_data  in  32  instruction word.
- iw_valid  in  1  instruction word valid.
- iw_ready  out  1  instruction word accepted when iw_valid & iw_ready.
- busy  out  1  reconfiguration in progress.
- done  out  1  one-cycle pulse when the new configuration is live.
- err  out  1  sticky configuration error.
- s_iv  in  1  upstream sample valid.
- s_rfd  out  1  ready-for-data to upstream.
- fir_rfd  in  1  FIR ready-for-data.
- fir_iv  out  1  FIR input valid.
- fir_mrst  out  1  synchronous reset to the FIR.
- fir_dec  out  6  FIR decimation modulus.
- fir_ncoef  out  10  FIR ending coefficient address.
- fir_acoef  out  10  FIR starting coefficient address.
- prst  out  1  program address reset.
- pwr  out  1  program write strobe.
- pdata  out  16  program half-word.

## Operation
- States: HALT, CHK, CLR, LOADL, LOADH, FLUSH, RUN.
- Reset (mrst):
  - State is HALT.
  - fir_mrst=1, busy=0, done=0, err=0, iw_ready=0, prst=0, pwr=0, pdata=0.
  - fir_dec=0, fir_ncoef=0, fir_acoef=0, s_rfd=0, fir_iv=0.
- HALT:
  - The FIR is held in reset.
  - cfg_go latches cfg_* into shadow registers, clears err, and moves to CHK.
- RUN:
  - fir_mrst=0.
  - cfg_go latches cfg_* and moves to CHK. fir_mrst is asserted from the next cycle, aborting any convolution in progress.
- CHK (1 cycle): goes to CLR. The CHK_EN build can instead set err and go to HALT (see Configuration).
- CLR (1 cycle):
  - prst=1.
  - Word counter is cleared.
  - Next state is FLUSH if shadow len=0, otherwise LOADL.
- LOADL:
  - iw_ready=1.
  - On a handshake: pdata←iw_data[15:0], pwr=1, iw_data[31:16] is held, go to LOADH.
  - With no handshake, the state is held and pwr=0.
- LOADH:
  - pdata←held upper half, pwr=1, counter increments.
  - Goes to FLUSH when the counter reaches len, otherwise to LOADL.
- FLUSH:
  - On entry, fir_dec, fir_ncoef and fir_acoef are all updated from the shadow registers in the same cycle.
  - fir_mrst is held for FLUSH_CYC cycles, then the block goes to RUN with done=1 for one cycle.
- busy=1 in every state except HALT and RUN.
- cfg_go is ignored while busy=1.
- Sample gating: s_rfd=RUN & fir_rfd, and fir_iv=s_iv & RUN. A sample presented outside RUN is dropped.
- A half-word pair is always written low then high, so the FIR program address remains even after each instruction.

## Timing
- All outputs are registered. Only s_rfd and fir_iv are combinational from state and inputs.
- Handshake at cycle t: pwr=1 with the low half at t+1; pwr=1 with the high half at t+2; earliest next handshake at t+2.
- Best-case load time is 2·len cycles. An iw_valid stall adds one cycle per stalled cycle.
- prst is asserted exactly one cycle, one cycle before the first pwr.
- cfg_go at cycle t:
  - fir_mrst=1 from t+1.
  - With len=0, done at t+3+FLUSH_CYC.
  - With len=N and no stalls, done at t+3+2N+FLUSH_CYC.
- mrst asserted mid-load aborts immediately to HALT. The program RAM contents are then undefined and the FIR stays in reset until the next cfg_go.

## Configuration
- Macro: PFIR_SEQ_CHECK_EN.
- When defined, CHK sets err=1 and returns to HALT without pulsing prst if any of these hold:
  - cfg_dec=0;
  - cfg_ncoef < cfg_acoef;
  - len≠0 and cfg_ncoef+2 ≥ len.
- When not defined, CHK never errors and err is tied to 0.

## Structure
- Shared package pfir_pkg holds:
  - the state enum;
  - field widths DEC_W=6, ADDR_W=10, LEN_W=11, PDATA_W=16.
- One natural sub-module, pfir_seq_ld: the half-word serializer that produces pwr/pdata from the iw handshake (LOADL/LOADH plus the word counter).

## Test plan
- Reset, then cfg_go with len=0, dec=8, acoef=0, ncoef=30 → prst pulse, FLUSH; done at t+3+FLUSH_CYC; fir_dec=8, fir_ncoef=30.
- cfg_go with len=3 and words 0xA0001234, 0x40005678, 0x8000FFFF with iw_valid held high → pdata 1234, A000, 5678, 4000, FFFF, 8000 with pwr on consecutive cycles; done at t+9+FLUSH_CYC.
- Same load with iw_valid deasserted for 5 cycles between words → pwr gaps only between LOADH and LOADL; pairs never split; done delayed by 5 cycles.
- s_iv held high through a reconfiguration started in RUN → fir_iv=0 and s_rfd=0 from cfg_go+1 until done; fir_mrst=1 for 3+2N+FLUSH_CYC cycles.
- mrst asserted during LOADH → immediate HALT; all outputs at reset values; a following cfg_go with len=1 loads correctly.
- PFIR_SEQ_CHECK_EN defined, cfg_dec=0 → err=1, no prst, state HALT; the next valid cfg_go clears err.
